spi_shift_engine: RTL and testbench

Serial shift engine for the SPI controller: the reader of the TX FIFO and the writer of the RX FIFO. It pops one word from the TX FIFO and frames it with chip-select. It serializes the word MSB-first on MOSI, generating SCLK in the configured CPOL/CPHA mode, and pushes the word captured on MISO into the RX FIFO. It sits between the two `spi_fifo` instances and the SPI pads.

---
 rtl/spi_shift_engine.sv | 189 ++++++++++++++++++
 tb/tb_spi_shift_engine.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine.sv
// SPI shift engine: pops TX words, frames them with cs_n, shifts MSB-first in CPOL/CPHA mode.
// Optional receive path (MISO capture, RX FIFO push) is built only when SPI_ENGINE_RX_EN is defined.
module spi_shift_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  enable_i,
    input  logic [DIV_WIDTH-1:0]  clk_div_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    output logic                  tx_rd_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_empty_i,
    output logic                  rx_wr_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    input  logic                  rx_full_i,
    output logic                  rx_overflow_o,
    output logic                  busy_o,
    output logic                  sclk_o,
    output logic                  mosi_o,
    output logic                  cs_n_o,
    input  logic                  miso_i
);

    localparam int EDGES  = 2 * DATA_WIDTH;
    localparam int ECNT_W = $clog2(EDGES) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t                 state;
    logic [DIV_WIDTH-1:0]   hcnt;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [ECNT_W-1:0]      ecnt;
    logic                   cpol_q;
    logic                   cpha_q;
    logic [DATA_WIDTH-1:0]  tx_shift;

    logic                   half_done;
    logic                   edge_fire;
    logic [ECNT_W-1:0]      ecnt_nxt;
    logic                   edge_lead;
    logic                   edge_last;
    logic                   pop_next;

    assign half_done = (hcnt == div_q);
    assign edge_fire = half_done && ((state == SETUP) || (state == SHIFT));
    assign ecnt_nxt  = ecnt + ECNT_W'(1);
    // Edges are numbered from 1: odd numbers are leading, even numbers trailing.
    assign edge_lead = ecnt_nxt[0];
    assign edge_last = (ecnt_nxt == ECNT_W'(EDGES));
    assign pop_next  = enable_i && !tx_empty_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= IDLE;
            hcnt     <= '0;
            div_q    <= '0;
            ecnt     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            tx_shift <= '0;
            tx_rd_o  <= 1'b0;
            busy_o   <= 1'b0;
            sclk_o   <= 1'b0;
            mosi_o   <= 1'b0;
            cs_n_o   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    sclk_o <= cpol_i;
                    cs_n_o <= 1'b1;
                    if (tx_rd_o) begin
                        // The pop strobe is visible this cycle; the FIFO head is still valid.
                        tx_rd_o  <= 1'b0;
                        tx_shift <= tx_data_i;
                        div_q    <= clk_div_i;
                        cpol_q   <= cpol_i;
                        cpha_q   <= cpha_i;
                        if (!cpha_i) begin
                            mosi_o <= tx_data_i[DATA_WIDTH-1];
                        end
                        cs_n_o   <= 1'b0;
                        busy_o   <= 1'b1;
                        hcnt     <= '0;
                        ecnt     <= '0;
                        state    <= SETUP;
                    end else begin
                        tx_rd_o <= pop_next;
                    end
                end
                SETUP, SHIFT: begin
                    if (half_done) begin
                        hcnt   <= '0;
                        ecnt   <= ecnt_nxt;
                        sclk_o <= ~sclk_o;
                        if (edge_lead && cpha_q) begin
                            mosi_o   <= tx_shift[DATA_WIDTH-1];
                            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        end else if (!edge_lead && !cpha_q && !edge_last) begin
                            mosi_o   <= tx_shift[DATA_WIDTH-2];
                            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                        state <= edge_last ? HOLD : SHIFT;
                    end else begin
                        hcnt <= hcnt + DIV_WIDTH'(1);
                    end
                end
                HOLD: begin
                    sclk_o <= cpol_q;
                    if (half_done) begin
                        hcnt   <= '0;
                        cs_n_o <= 1'b1;
                        state  <= GAP;
                    end else begin
                        hcnt <= hcnt + DIV_WIDTH'(1);
                    end
                end
                GAP: begin
                    sclk_o <= cpol_q;
                    cs_n_o <= 1'b1;
                    if (half_done) begin
                        // Deciding the next pop here lets back-to-back words pop on IDLE entry.
                        hcnt    <= '0;
                        busy_o  <= 1'b0;
                        tx_rd_o <= pop_next;
                        state   <= IDLE;
                    end else begin
                        hcnt <= hcnt + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy_o  <= 1'b0;
                    cs_n_o  <= 1'b1;
                    tx_rd_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_ENGINE_RX_EN
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_next;
    logic                  sample;

    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
    assign sample  = edge_fire && (edge_lead != cpha_q);
    assign rx_next = sample ? {rx_shift[DATA_WIDTH-2:0], miso_i} : rx_shift;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_shift      <= '0;
            rx_data_o     <= '0;
            rx_wr_o       <= 1'b0;
            rx_overflow_o <= 1'b0;
        end else begin
            rx_wr_o       <= 1'b0;
            rx_overflow_o <= 1'b0;
            if (edge_fire) begin
                rx_shift <= rx_next;
            end
            if (edge_fire && edge_last) begin
                if (!rx_full_i) begin
                    rx_wr_o   <= 1'b1;
                    rx_data_o <= rx_next;
                end else begin
                    rx_overflow_o <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_rx;

    assign unused_rx     = miso_i ^ rx_full_i;
    assign rx_wr_o       = 1'b0;
    assign rx_overflow_o = 1'b0;
    assign rx_data_o     = '0;
`endif

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: timing-rule reference model plus directed and random words.
module tb_spi_shift_engine;

    localparam int W  = 8;
    localparam int DW = 16;
`ifdef SPI_ENGINE_RX_EN
    localparam bit RX = 1'b1;
`else
    localparam bit RX = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          enable_i;
    logic [DW-1:0] clk_div_i;
    logic          cpol_i;
    logic          cpha_i;
    logic          tx_rd_o;
    logic [W-1:0]  tx_data_i;
    logic          tx_empty_i;
    logic          rx_wr_o;
    logic [W-1:0]  rx_data_o;
    logic          rx_full_i;
    logic          rx_overflow_o;
    logic          busy_o;
    logic          sclk_o;
    logic          mosi_o;
    logic          cs_n_o;
    logic          miso_i;

    logic          loop_en;
    logic          miso_model;
    logic [W-1:0]  miso_pat;
    logic          rand_miso;
    logic [W-1:0]  txq[$];

    assign miso_i = loop_en ? mosi_o : miso_model;

    spi_shift_engine #(.DATA_WIDTH(W), .DIV_WIDTH(DW)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .enable_i(enable_i), .clk_div_i(clk_div_i),
        .cpol_i(cpol_i), .cpha_i(cpha_i), .tx_rd_o(tx_rd_o), .tx_data_i(tx_data_i),
        .tx_empty_i(tx_empty_i), .rx_wr_o(rx_wr_o), .rx_data_o(rx_data_o), .rx_full_i(rx_full_i),
        .rx_overflow_o(rx_overflow_o), .busy_o(busy_o), .sclk_o(sclk_o), .mosi_o(mosi_o),
        .cs_n_o(cs_n_o), .miso_i(miso_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state: one word in flight, timed from its pop cycle t0.
    bit           act = 1'b0;
    int           t0 = 0;
    int           hh = 1;
    int           t, k, j;
    bit           m_cpol, m_cpha, m_full;
    logic [W-1:0] m_tx, m_rx;
    logic [W-1:0] last_rx = '0;
    logic [W-1:0] exp_rx;
    bit           prev_en = 0, prev_ne = 0, prev_cpol = 0, prev_rst = 0, prev_idle = 0, cur_idle;
    logic         prev_sclk = 1'b0;
    bit           exp_wr, exp_ovf;

    int           rd_cnt = 0, wr_cnt = 0, ovf_cnt = 0, cs_low_cnt = 0, cs_hi_run = 0, last_gap = 0;
    int           pop_cyc[$];
    logic [W-1:0] lead_bits = '0;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    always @(negedge clk_i) begin
        cyc++;
        if (!reset_n_i) begin
            act      = 1'b0;
            last_rx  = '0;
            cur_idle = 1'b0;
            chk("reset_cs_n", cs_n_o, 1);
            chk("reset_sclk", sclk_o, 0);
            chk("reset_mosi", mosi_o, 0);
            chk("reset_busy", busy_o, 0);
            chk("reset_tx_rd", tx_rd_o, 0);
            chk("reset_rx_wr", rx_wr_o, 0);
            chk("reset_rx_ovf", rx_overflow_o, 0);
            chk("reset_rx_data", rx_data_o, 0);
        end else begin
            t = cyc - t0;
            if (act && t > (2 * W + 2) * hh) begin
                act = 1'b0;
                if (prev_en && prev_ne && prev_rst) chk("b2b_pop", tx_rd_o, 1);
            end
            if (tx_rd_o) begin
                chk("pop_not_empty", tx_empty_i, 0);
                chk("pop_while_idle", act, 0);
                chk("pop_enabled", prev_en, 1);
                rd_cnt++;
                pop_cyc.push_back(cyc);
                act       = 1'b1;
                t0        = cyc;
                hh        = int'(clk_div_i) + 1;
                m_cpol    = cpol_i;
                m_cpha    = cpha_i;
                m_tx      = tx_data_i;
                m_rx      = loop_en ? tx_data_i : miso_pat;
                m_full    = 1'b0;
                lead_bits = '0;
            end
            t = cyc - t0;
            exp_wr  = 1'b0;
            exp_ovf = 1'b0;
            if (act && t >= 1) begin
                k = (t - 1) / hh;
                if (k > 2 * W) k = 2 * W;
                chk("cs_n", cs_n_o, (t <= (2 * W + 1) * hh) ? 0 : 1);
                chk("busy", busy_o, 1);
                chk("sclk", sclk_o, m_cpol ^ k[0]);
                if (!m_cpha) begin
                    j = (k / 2 > W - 1) ? W - 1 : k / 2;
                    chk("mosi_cpha0", mosi_o, m_tx[W-1-j]);
                end else if (k >= 1) begin
                    chk("mosi_cpha1", mosi_o, m_tx[W-(k+1)/2]);
                end
                if (t == 2 * W * hh) m_full = rx_full_i;
                if (RX && t == 1 + 2 * W * hh) begin
                    exp_wr  = !m_full;
                    exp_ovf = m_full;
                    if (!m_full) last_rx = m_rx;
                end
                cur_idle = 1'b0;
            end else begin
                chk("idle_cs_n", cs_n_o, 1);
                chk("idle_busy", busy_o, 0);
                if (prev_idle && prev_rst && prev_cpol == cpol_i) chk("idle_sclk", sclk_o, cpol_i);
                cur_idle = 1'b1;
            end
            exp_rx = RX ? last_rx : '0;
            chk("rx_wr", rx_wr_o, exp_wr);
            chk("rx_ovf", rx_overflow_o, exp_ovf);
            chk("rx_data", rx_data_o, exp_rx);

            if (!cs_n_o) begin
                cs_low_cnt++;
                if (cs_hi_run > 0) last_gap = cs_hi_run;
                cs_hi_run = 0;
                if (sclk_o != prev_sclk && prev_sclk == m_cpol) lead_bits = {lead_bits[W-2:0], mosi_o};
            end else begin
                cs_hi_run++;
            end
            if (rx_wr_o) wr_cnt++;
            if (rx_overflow_o) ovf_cnt++;
        end
        prev_sclk = sclk_o;
        prev_en   = enable_i;
        prev_ne   = !tx_empty_i;
        prev_cpol = cpol_i;
        prev_rst  = reset_n_i;
        prev_idle = cur_idle;
    end

    task automatic refresh();
        tx_empty_i = (txq.size() == 0);
        tx_data_i  = (txq.size() > 0) ? txq[0] : '0;
    endtask

    task automatic push(input logic [W-1:0] d);
        txq.push_back(d);
        refresh();
    endtask

    // One clock cycle; the TX FIFO model pops after the edge that ends a tx_rd_o cycle.
    task automatic tick();
        logic rd;
        int   tt, kk, s;
        logic mb;
        @(negedge clk_i);
        rd = tx_rd_o && reset_n_i;
        @(posedge clk_i);
        #1;
        if (rd && txq.size() > 0) void'(txq.pop_front());
        refresh();
        if (rand_miso) miso_pat = W'($urandom);
        mb = 1'($urandom_range(0, 1));
        if (act) begin
            tt = cyc + 1 - t0;
            kk = (tt >= 1) ? (tt - 1) / hh : 0;
            s  = m_cpha ? kk / 2 : (kk + 1) / 2;
            if (s < W) mb = m_rx[W-1-s];
        end
        miso_model = mb;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_pop(input int budget);
        int n0;
        int i;
        n0 = rd_cnt;
        i  = 0;
        while (rd_cnt == n0 && i < budget) begin
            tick();
            i++;
        end
        checks++;
        if (rd_cnt == n0) begin
            errors++;
            $display("FAIL wait_pop: no tx_rd_o within %0d cycles", budget);
        end
    endtask

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; ovf_cnt = 0; cs_low_cnt = 0;
        pop_cyc.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [W-1:0] saved_rx;

    initial begin
        reset_n_i = 1'b0; enable_i = 1'b0; clk_div_i = 16'd1; cpol_i = 1'b0; cpha_i = 1'b0;
        rx_full_i = 1'b0; loop_en = 1'b0; miso_pat = '0; miso_model = 1'b0; rand_miso = 1'b0;
        refresh();
        run(3);
        reset_n_i = 1'b1;
        run(3);

        // Mode 0, H=2, MISO looped back to MOSI.
        clear_counts();
        loop_en = 1'b1; enable_i = 1'b1;
        push(8'hA5);
        run(50);
        chk("t1_pops", rd_cnt, 1);
        chk("t1_cs_low", cs_low_cnt, 34);
        chk("t1_lead_bits", lead_bits, 8'hA5);
        chk("t1_rx_wr", wr_cnt, RX ? 1 : 0);
        chk("t1_rx_data", rx_data_o, RX ? 8'hA5 : 8'h00);
        chk("t1_sclk_idle", sclk_o, 0);

        // Mode 3, MISO driven with 0xC3.
        loop_en = 1'b0; cpol_i = 1'b1; cpha_i = 1'b1; miso_pat = 8'hC3;
        run(3);
        clear_counts();
        push(8'h3C);
        run(50);
        chk("t2_pops", rd_cnt, 1);
        chk("t2_lead_bits", lead_bits, 8'h3C);
        chk("t2_rx_data", rx_data_o, RX ? 8'hC3 : 8'h00);
        chk("t2_sclk_idle", sclk_o, 1);

        // Three queued words at H=1: back-to-back spacing and cs_n gap.
        cpol_i = 1'b0; cpha_i = 1'b0; clk_div_i = 16'd0; rand_miso = 1'b1;
        run(3);
        clear_counts();
        for (int i = 0; i < 3; i++) push(W'($urandom));
        run(3 * 19 + 10);
        chk("t3_pops", rd_cnt, 3);
        chk("t3_spacing0", pop_cyc.size() > 1 ? pop_cyc[1] - pop_cyc[0] : 0, 19);
        chk("t3_spacing1", pop_cyc.size() > 2 ? pop_cyc[2] - pop_cyc[1] : 0, 19);
        chk("t3_cs_gap", last_gap, 2);

        // RX FIFO full: word dropped, rx_data_o held.
        rand_miso = 1'b0; miso_pat = 8'h81; clk_div_i = 16'd1; rx_full_i = 1'b1;
        saved_rx = RX ? last_rx : '0;
        clear_counts();
        push(8'h5A);
        run(50);
        chk("t4_rx_wr", wr_cnt, 0);
        chk("t4_overflow", ovf_cnt, RX ? 1 : 0);
        chk("t4_rx_hold", rx_data_o, saved_rx);
        rx_full_i = 1'b0;

        // enable_i dropped mid-word with another word queued.
        clear_counts();
        push(8'h96); push(8'h69);
        wait_pop(10);
        run(10);
        enable_i = 1'b0;
        run(60);
        chk("t5_pops", rd_cnt, 1);
        chk("t5_busy", busy_o, 0);
        chk("t5_queue_left", txq.size(), 1);

        // Reset at SCLK edge 7, then restart from the queue.
        loop_en = 1'b1;
        push(8'h77);
        clear_counts();
        enable_i = 1'b1;
        wait_pop(10);
        run(14);
        reset_n_i = 1'b0;
        tick();
        chk("t6_no_rx_wr", wr_cnt, 0);
        tick();
        reset_n_i = 1'b1;
        clear_counts();
        run(50);
        chk("t6_restart_pops", rd_cnt, 1);
        chk("t6_restart_rx", rx_data_o, RX ? 8'h77 : 8'h00);
        chk("t6_queue_empty", txq.size(), 0);

        // Randomized words: mode, divider, RX full and MISO data all vary.
        loop_en = 1'b0; rand_miso = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cpol_i    = 1'($urandom_range(0, 1));
            cpha_i    = 1'($urandom_range(0, 1));
            clk_div_i = DW'($urandom_range(0, 3));
            rx_full_i = ($urandom_range(0, 3) == 0);
            run(3);
            push(W'($urandom));
            run(3 + (2 * W + 2) * (int'(clk_div_i) + 1) + 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
